ts_tx_gen: RTL and testbench
============================

TS_TX_GEN -- requirements
Module: ts_tx_gen

Interface
REQ-001 SHALL have parameter COM_SYM, default 8'hBC, comma symbol (K28.5).
REQ-002 SHALL have parameter PAD_SYM, default 8'hF7, PAD symbol (K23.7).
REQ-003 SHALL have parameter TS1_ID, default 8'h4A, TS1 identifier symbol (D10.2).
REQ-004 SHALL have parameter TS2_ID, default 8'h45, TS2 identifier symbol (D5.2).
REQ-005 SHALL have parameter IDLE_SYM, default 8'h00, symbol driven when not transmitting.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port en, input, 1, synchronous enable; low aborts and holds idle.
REQ-009 SHALL have port start, input, 1, begin a burst (sampled in IDLE only).
REQ-010 SHALL have port stop, input, 1, end burst at next ordered-set boundary (sampled in SEND only).
REQ-011 SHALL have port os_sel, input, 1, 0 = TS1, 1 = TS2.
REQ-012 SHALL have port os_count, input, 8, ordered sets per burst; 0 = continuous until stop.
REQ-013 SHALL have ports linkn, lanen, nfts, dri, tc, input, 8 each, TS field values.
REQ-014 SHALL have port txdata, output, 8, symbol stream.
REQ-015 SHALL have port txdatak, output, 1, high when txdata is a K symbol.
REQ-016 SHALL have port txvalid, output, 1, high while a TS symbol is driven.
REQ-017 SHALL have port busy, output, 1, high in SEND state.
REQ-018 SHALL have port done, output, 1, one-cycle pulse on final symbol of burst.
REQ-019 SHALL have port os_sent, output, 16, ordered sets completed in current burst, saturating.

Function
REQ-020 SHALL implement states IDLE and SEND with a 4-bit symbol index 0..15.
REQ-021 IDLE->SEND SHALL occur when start=1 and en=1; os_sent cleared to 0 and the burst counter loaded from os_count in the same edge.
REQ-022 SHALL drive registered outputs: COM appears on txdata the cycle after start is sampled (latency 1).
REQ-023 Per ordered set SHALL emit, in order: COM, linkn, lanen, nfts, dri, tc, then 10 x (TS1_ID or TS2_ID).
REQ-024 os_sel and all field inputs SHALL be captured when index 0 is issued and held constant for that 16-symbol set; changes take effect only at the next set.
REQ-025 txdatak SHALL be 1 on index 0, and on index 1 or 2 when the captured field equals PAD_SYM; 0 otherwise.
REQ-026 Sets SHALL be back-to-back: index 0 of set n+1 directly follows index 15 of set n, no gap cycles.
REQ-027 os_sent SHALL increment by 1 on each index-15 cycle, saturating at 16'hFFFF.
REQ-028 Burst SHALL end after index 15 when os_count!=0 and os_sent reaches os_count, or when stop was seen at any cycle of the current set (stop is latched until the boundary).
REQ-029 done SHALL pulse with index 15 of the final set; busy and txvalid fall the following cycle.
REQ-030 In IDLE: txdata=IDLE_SYM, txdatak=0, txvalid=0, busy=0, done=0.
REQ-031 start while busy SHALL be ignored; start in the cycle after done SHALL begin a new burst normally.
REQ-032 en=0 in SEND SHALL return to IDLE at the next edge mid-set with idle outputs, no done pulse; os_sent holds its value.
REQ-033 stop with os_count=0 SHALL be the only way to end a continuous burst other than en=0 or reset.

Reset
REQ-034 reset=1 SHALL asynchronously force IDLE, index 0, txdata=IDLE_SYM, txdatak=0, txvalid=0, busy=0, done=0, os_sent=0, stop latch cleared.
REQ-035 Reset asserted mid-set SHALL truncate the set immediately; no partial completion after deassertion.

Verification
REQ-036 start, os_sel=0, os_count=1, linkn=8'h01, lanen=8'h00 -> cycles 1..16: BC,01,00,nfts,dri,tc,10x4A; done on cycle 16; os_sent=1.
REQ-037 os_count=3, os_sel=1 -> 48 contiguous symbols, COM at cycles 1, 17, 33, txdatak=1 only there, done at cycle 48, os_sent=3.
REQ-038 os_count=0, stop pulsed at symbol 7 of set 2 -> set 2 completes, done on its index 15, os_sent=2.
REQ-039 linkn=lanen=8'hF7 -> txdatak=1 on indices 0,1,2; os_sel toggled mid-set -> identifier changes only from next set.
REQ-040 reset at symbol 5, and separately en=0 at symbol 9 -> txdata=00, txvalid=0 immediately/next edge, no done pulse.

Source files
------------

// File: rtl/ts_tx_gen.sv
// ts_tx_gen: TS1/TS2 ordered-set burst generator. Emits back-to-back 16-symbol
// sets (COM, link, lane, N_FTS, rate, training control, 10 x identifier) on registered outputs.
module ts_tx_gen #(
    parameter logic [7:0] COM_SYM  = 8'hBC,
    parameter logic [7:0] PAD_SYM  = 8'hF7,
    parameter logic [7:0] TS1_ID   = 8'h4A,
    parameter logic [7:0] TS2_ID   = 8'h45,
    parameter logic [7:0] IDLE_SYM = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        start,
    input  logic        stop,
    input  logic        os_sel,
    input  logic [7:0]  os_count,
    input  logic [7:0]  linkn,
    input  logic [7:0]  lanen,
    input  logic [7:0]  nfts,
    input  logic [7:0]  dri,
    input  logic [7:0]  tc,
    output logic [7:0]  txdata,
    output logic        txdatak,
    output logic        txvalid,
    output logic        busy,
    output logic        done,
    output logic [15:0] os_sent,
    output logic        fsm_state
);

    // Handshake: start is accepted only while busy=0 and en=1; from the next
    // cycle txvalid=busy=1 and every cycle carries one symbol (no backpressure)
    // until the cycle after done, or the edge after en drops.
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t      state, state_nx;
    logic [3:0]  idx, idx_nx;
    logic        stop_lat, stop_lat_nx;
    logic [7:0]  burst_len, burst_len_nx;
    logic [15:0] os_sent_nx, os_sent_inc;
    logic        cap;
    logic        cap_sel;
    logic [7:0]  cap_linkn, cap_lanen, cap_nfts, cap_dri, cap_tc;
    logic [7:0]  txdata_nx;
    logic        txdatak_nx, done_nx, final_set;

    assign os_sent_inc = (os_sent == 16'hFFFF) ? os_sent : os_sent + 16'd1;

    // Decided when index 15 is issued, so stop seen during the index-15 cycle
    // itself belongs to the following set.
    assign final_set = ((burst_len != 8'd0) && (os_sent_inc == {8'h00, burst_len}))
                       || stop_lat || stop;

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        stop_lat_nx  = stop_lat;
        burst_len_nx = burst_len;
        os_sent_nx   = os_sent;
        cap          = 1'b0;
        done_nx      = 1'b0;
        case (state)
            IDLE: begin
                if (en && start) begin
                    state_nx     = SEND;
                    idx_nx       = 4'd0;
                    stop_lat_nx  = 1'b0;
                    burst_len_nx = os_count;
                    os_sent_nx   = 16'd0;
                    cap          = 1'b1;
                end
            end
            SEND: begin
                if (!en) begin
                    state_nx    = IDLE;
                    idx_nx      = 4'd0;
                    stop_lat_nx = 1'b0;
                end else if (idx == 4'd15) begin
                    if (done) begin
                        state_nx    = IDLE;
                        idx_nx      = 4'd0;
                        stop_lat_nx = 1'b0;
                    end else begin
                        idx_nx      = 4'd0;
                        stop_lat_nx = stop;
                        cap         = 1'b1;
                    end
                end else begin
                    idx_nx      = idx + 4'd1;
                    stop_lat_nx = stop_lat | stop;
                    if (idx == 4'd14) begin
                        os_sent_nx = os_sent_inc;
                        done_nx    = final_set;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        txdata_nx  = IDLE_SYM;
        txdatak_nx = 1'b0;
        if (state_nx == SEND) begin
            case (idx_nx)
                4'd0: begin
                    txdata_nx  = COM_SYM;
                    txdatak_nx = 1'b1;
                end
                4'd1: begin
                    txdata_nx  = cap_linkn;
                    txdatak_nx = (cap_linkn == PAD_SYM);
                end
                4'd2: begin
                    txdata_nx  = cap_lanen;
                    txdatak_nx = (cap_lanen == PAD_SYM);
                end
                4'd3:    txdata_nx = cap_nfts;
                4'd4:    txdata_nx = cap_dri;
                4'd5:    txdata_nx = cap_tc;
                default: txdata_nx = cap_sel ? TS2_ID : TS1_ID;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 4'd0;
            stop_lat  <= 1'b0;
            burst_len <= 8'd0;
            os_sent   <= 16'd0;
            txdata    <= IDLE_SYM;
            txdatak   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            stop_lat  <= stop_lat_nx;
            burst_len <= burst_len_nx;
            os_sent   <= os_sent_nx;
            txdata    <= txdata_nx;
            txdatak   <= txdatak_nx;
            done      <= done_nx;
        end
    end

    // Field snapshot taken as index 0 is issued; held for the whole set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_sel   <= 1'b0;
            cap_linkn <= 8'd0;
            cap_lanen <= 8'd0;
            cap_nfts  <= 8'd0;
            cap_dri   <= 8'd0;
            cap_tc    <= 8'd0;
        end else if (cap) begin
            cap_sel   <= os_sel;
            cap_linkn <= linkn;
            cap_lanen <= lanen;
            cap_nfts  <= nfts;
            cap_dri   <= dri;
            cap_tc    <= tc;
        end
    end

    assign busy      = (state == SEND);
    assign txvalid   = (state == SEND);
    assign fsm_state = (state == SEND);

endmodule

// File: tb/tb_ts_tx_gen.sv
// tb_ts_tx_gen: directed and randomized bursts for ts_tx_gen; expected streams
// are built per burst from the ordered-set layout and the recorded input history.
module tb_ts_tx_gen;

    localparam int W = 29; // {state, os_sent[15:0], done, busy, txvalid, txdatak, txdata[7:0]}
    localparam int NONE = 1000;

    logic        clk = 1'b0;
    logic        reset, en, start, stop, os_sel;
    logic [7:0]  os_count, linkn, lanen, nfts, dri, tc;
    logic [7:0]  txdata;
    logic        txdatak, txvalid, busy, done, fsm_state;
    logic [15:0] os_sent;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [15:0]  last_os;

    logic        g_sel[128];
    logic        g_start[128];
    logic        g_stop[128];
    logic        g_en[128];
    logic [7:0]  g_link[128];
    logic [7:0]  g_lane[128];
    logic [7:0]  g_nfts[128];
    logic [7:0]  g_dri[128];
    logic [7:0]  g_tc[128];

    ts_tx_gen dut (
        .clk(clk), .reset(reset), .en(en), .start(start), .stop(stop),
        .os_sel(os_sel), .os_count(os_count), .linkn(linkn), .lanen(lanen),
        .nfts(nfts), .dri(dri), .tc(tc), .txdata(txdata), .txdatak(txdatak),
        .txvalid(txvalid), .busy(busy), .done(done), .os_sent(os_sent),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pack(input logic st, input logic [15:0] os,
                                          input logic dn, input logic bz, input logic vl,
                                          input logic k, input logic [7:0] d);
        return {st, os, dn, bz, vl, k, d};
    endfunction

    function automatic logic [7:0] rnd_field();
        return ($urandom_range(0, 3) == 0) ? 8'hF7 : 8'($urandom_range(0, 255));
    endfunction

    // Sets in a burst: os_count limit and/or the set in which stop lands
    // (stop seen on a set's index-15 cycle carries into the next set).
    function automatic int sets_in_burst(input int cnt, input int se);
        int nc, ns;
        nc = (cnt == 0) ? NONE : cnt;
        ns = NONE;
        if (se > 0) ns = (se - 1) / 16 + 1 + (((se - 1) % 16 == 15) ? 1 : 0);
        return (nc < ns) ? nc : ns;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input string ctx);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s.queue: observed empty expected entry", ctx);
        end else begin
            e = exp_q.pop_front();
            chk({ctx, ".txdata"},  16'(txdata),    16'(e[7:0]));
            chk({ctx, ".txdatak"}, 16'(txdatak),   16'(e[8]));
            chk({ctx, ".txvalid"}, 16'(txvalid),   16'(e[9]));
            chk({ctx, ".busy"},    16'(busy),      16'(e[10]));
            chk({ctx, ".done"},    16'(done),      16'(e[11]));
            chk({ctx, ".os_sent"}, os_sent,        e[27:12]);
            chk({ctx, ".state"},   16'(fsm_state), 16'(e[28]));
        end
    endtask

    // kind: 0 = runs to done, 1 = en dropped at edge ae, 2 = reset during cycle ae.
    // mode: 0 random fields, 1 fixed 01/00 TS1, 2 TS2 without PAD, 3 PAD link/lane with os_sel toggling.
    task automatic run_burst(input string name, input int cnt, input int se,
                             input int kind, input int ae, input int mode);
        int n_sets, burst_last, last_t, s, p, ce;
        logic [7:0] d;
        logic k;
        for (int e = 0; e < 128; e++) begin
            g_sel[e]   = 1'($urandom_range(0, 1));
            g_link[e]  = rnd_field();
            g_lane[e]  = rnd_field();
            g_nfts[e]  = rnd_field();
            g_dri[e]   = rnd_field();
            g_tc[e]    = rnd_field();
            g_start[e] = (e == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            g_stop[e]  = 1'b0;
            g_en[e]    = 1'b1;
            if (mode == 1) begin
                g_sel[e] = 1'b0; g_link[e] = 8'h01; g_lane[e] = 8'h00;
            end else if (mode == 2) begin
                g_sel[e] = 1'b1;
                g_link[e] &= 8'h7F; g_lane[e] &= 8'h7F;
                g_nfts[e] &= 8'h7F; g_dri[e] &= 8'h7F; g_tc[e] &= 8'h7F;
            end else if (mode == 3) begin
                g_sel[e] = 1'(e % 2); g_link[e] = 8'hF7; g_lane[e] = 8'hF7;
            end
        end
        g_stop[0] = 1'($urandom_range(0, 1));
        if (se > 0) g_stop[se] = 1'b1;
        if (kind == 1) g_en[ae] = 1'b0;

        n_sets     = sets_in_burst(cnt, se);
        burst_last = (kind != 0) ? ae : 16 * n_sets;
        last_t     = (kind == 2) ? ae : burst_last + 1;

        for (int t = 1; t <= last_t; t++) begin
            if (t <= burst_last) begin
                s  = (t - 1) / 16;
                p  = (t - 1) % 16;
                ce = 16 * s;
                k  = 1'b0;
                case (p)
                    0: begin d = 8'hBC; k = 1'b1; end
                    1: begin d = g_link[ce]; k = (d == 8'hF7); end
                    2: begin d = g_lane[ce]; k = (d == 8'hF7); end
                    3: d = g_nfts[ce];
                    4: d = g_dri[ce];
                    5: d = g_tc[ce];
                    default: d = g_sel[ce] ? 8'h45 : 8'h4A;
                endcase
                exp_q.push_back(pack(1'b1, 16'(t / 16), (kind == 0) && (t == burst_last),
                                     1'b1, 1'b1, k, d));
            end else begin
                exp_q.push_back(pack(1'b0, 16'(burst_last / 16), 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
            end
        end

        for (int e = 0; e < last_t; e++) begin
            @(negedge clk);
            en       = g_en[e];
            start    = g_start[e];
            stop     = g_stop[e];
            os_sel   = g_sel[e];
            os_count = (e == 0) ? 8'(cnt) : 8'($urandom_range(0, 255));
            linkn    = g_link[e];
            lanen    = g_lane[e];
            nfts     = g_nfts[e];
            dri      = g_dri[e];
            tc       = g_tc[e];
            @(posedge clk);
            #1;
            check_cycle(name);
        end

        if (kind == 2) begin
            #2 reset = 1'b1;
            #1;
            exp_q.push_back(pack(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
            check_cycle({name, ".in_reset"});
            #1 reset = 1'b0;
            last_os = 16'd0;
        end else begin
            last_os = 16'(burst_last / 16);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Idle cycles: start only offered while en is low, so nothing may launch.
    task automatic run_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en       = 1'($urandom_range(0, 1));
            start    = en ? 1'b0 : 1'($urandom_range(0, 1));
            stop     = 1'($urandom_range(0, 1));
            os_sel   = 1'($urandom_range(0, 1));
            os_count = 8'($urandom_range(0, 255));
            linkn    = rnd_field();
            @(posedge clk);
            #1;
            exp_q.push_back(pack(1'b0, last_os, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
            check_cycle("gap");
        end
    endtask

    initial begin
        int cnt, se, kind, ae, n, lim;
        reset = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; os_sel = 1'b0;
        os_count = 8'd0; linkn = 8'd0; lanen = 8'd0; nfts = 8'd0; dri = 8'd0; tc = 8'd0;
        last_os = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(pack(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        check_cycle("reset");
        @(negedge clk);
        reset = 1'b0;

        run_burst("single_ts1", 1, 0, 0, 0, 1);
        run_burst("three_ts2", 3, 0, 0, 0, 2);
        run_gap(2);
        run_burst("cont_stop_s2", 0, 24, 0, 0, 0);
        run_burst("pad_fields", 2, 0, 0, 0, 3);
        run_burst("stop_on_idx15", 0, 16, 0, 0, 0);
        run_burst("reset_mid_set", 0, 0, 2, 6, 0);
        run_gap(2);
        run_burst("en_drop_mid_set", 0, 0, 1, 10, 0);
        run_gap(1);

        for (int i = 0; i < 10; i++) begin
            cnt  = $urandom_range(0, 4);
            kind = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
            se   = (cnt == 0 || $urandom_range(0, 2) == 0)
                   ? $urandom_range(1, (cnt == 0) ? 60 : 16 * cnt) : 0;
            n    = sets_in_burst(cnt, se);
            lim  = (n == NONE) ? 60 : 16 * n - 1;
            ae   = (kind != 0) ? $urandom_range(1, lim) : 0;
            run_burst("random", cnt, se, kind, ae, 0);
            run_gap($urandom_range(0, 2));
        end

        run_gap(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
